// File: rtl/sdram_cmd_sequencer_pkg.sv
// Shared definitions for the SDRAM command sequencer:
//   - default size/timing parameters
//   - SDRAM command encodings as {ras_n, cas_n, we_n}
//   - sequencer state encodings
//   - width of the shared wait timer
package sdram_cmd_sequencer_pkg;

    localparam int DEF_ROWSIZE   = 12;
    localparam int DEF_COLSIZE   = 9;
    localparam int DEF_BANKSIZE  = 2;
    localparam int DEF_T_RCD     = 2;
    localparam int DEF_CAS_LAT   = 2;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_T_RP      = 2;
    localparam int DEF_T_RFC     = 7;
    localparam int DEF_T_MRD     = 2;

    localparam int TIMER_W = 8;

    // {ras_n, cas_n, we_n}; cs_n is held low so every cycle is a real command
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_MRS   = 3'b000;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_ACT  = 4'd1;
    localparam logic [3:0] ST_RCD  = 4'd2;
    localparam logic [3:0] ST_RW   = 4'd3;
    localparam logic [3:0] ST_DATA = 4'd4;
    localparam logic [3:0] ST_PRE  = 4'd5;
    localparam logic [3:0] ST_REF  = 4'd6;
    localparam logic [3:0] ST_MRS  = 4'd7;
    localparam logic [3:0] ST_WAIT = 4'd8;

endpackage

// File: rtl/sdram_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// Ports:
//   clk0, reset     clock, async active-high reset
//   load, load_val  load the counter with the number of cycles to spend in a state
//   count           current count (loaded value on the first cycle of the state)
//   done            last cycle of the timed state (count at or below 1)
// The counter stops at zero rather than wrapping.
module sdram_timer
    import sdram_cmd_sequencer_pkg::*;
(
    input  logic               clk0,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count,
    output logic               done
);

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign done = (count <= TIMER_W'(1));

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: turns one-cycle do_* requests into timed SDRAM
// command sequences and produces datapath strobes.
// Ports:
//   clk0, reset               clock, async active-high reset
//   do_reada/do_writea        read/write with auto-precharge request
//   do_refresh/do_preacharge  auto-refresh / precharge-all request
//   do_load_mod               mode register load request
//   addr                      {bank,row,col}, captured when a request is accepted
//   mode_reg                  value driven on sdr_addr for LOAD MODE
//   sdr_cs_n..sdr_we_n        registered SDRAM command pins
//   sdr_ba, sdr_addr          registered bank / address pins
//   oe, rd_valid              write-data drive / read-data valid strobes
//   cmd_ack                   READ/WRITE/REF/PRE/MRS on the pins this cycle
//   busy                      sequencer not idle
//   cmd_err                   a request was dropped in the previous cycle
module sdram_cmd_sequencer
    import sdram_cmd_sequencer_pkg::*;
#(
    parameter int ROWSIZE   = DEF_ROWSIZE,
    parameter int COLSIZE   = DEF_COLSIZE,
    parameter int BANKSIZE  = DEF_BANKSIZE,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int CAS_LAT   = DEF_CAS_LAT,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int T_RP      = DEF_T_RP,
    parameter int T_RFC     = DEF_T_RFC,
    parameter int T_MRD     = DEF_T_MRD
) (
    input  logic                                 clk0,
    input  logic                                 reset,
    input  logic                                 do_reada,
    input  logic                                 do_writea,
    input  logic                                 do_refresh,
    input  logic                                 do_preacharge,
    input  logic                                 do_load_mod,
    input  logic [BANKSIZE+ROWSIZE+COLSIZE-1:0]  addr,
    input  logic [ROWSIZE-1:0]                   mode_reg,
    output logic                                 sdr_cs_n,
    output logic                                 sdr_ras_n,
    output logic                                 sdr_cas_n,
    output logic                                 sdr_we_n,
    output logic [BANKSIZE-1:0]                  sdr_ba,
    output logic [ROWSIZE-1:0]                   sdr_addr,
    output logic                                 oe,
    output logic                                 rd_valid,
    output logic                                 cmd_ack,
    output logic                                 busy,
    output logic                                 cmd_err
);

    localparam int ADDR_W = BANKSIZE + ROWSIZE + COLSIZE;

    // Cycles spent in each timed state
    localparam logic [TIMER_W-1:0] RCD_CYC = TIMER_W'(T_RCD - 1);
    localparam logic [TIMER_W-1:0] RD_CYC  = TIMER_W'(CAS_LAT - 1 + BURST_LEN);
    localparam logic [TIMER_W-1:0] WR_CYC  = TIMER_W'(BURST_LEN - 1);
    localparam logic [TIMER_W-1:0] RP_CYC  = TIMER_W'(T_RP);
    localparam logic [TIMER_W-1:0] PRE_CYC = TIMER_W'(T_RP - 1);
    localparam logic [TIMER_W-1:0] RFC_CYC = TIMER_W'(T_RFC - 1);
    localparam logic [TIMER_W-1:0] MRD_CYC = TIMER_W'(T_MRD - 1);
    localparam logic [TIMER_W-1:0] BL_CNT  = TIMER_W'(BURST_LEN);

    logic [3:0]          state, state_nxt;
    logic                t_load, t_done;
    logic [TIMER_W-1:0]  t_val, t_count;
    logic                wr_q;
    logic [BANKSIZE-1:0] bank_q;
    logic [COLSIZE-1:0]  col_q;
    logic [4:0]          req;
    logic                req_multi;
    logic [ROWSIZE-1:0]  rw_addr, pre_addr;

    assign req       = {do_refresh, do_preacharge, do_load_mod, do_writea, do_reada};
    assign req_multi = (req & (req - 5'd1)) != 5'd0;

    sdram_timer u_timer (
        .clk0     (clk0),
        .reset    (reset),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_count),
        .done     (t_done)
    );

    // Next state and timer load; the timer is loaded on the edge that enters a timed state
    always_comb begin
        state_nxt = state;
        t_load    = 1'b0;
        t_val     = '0;
        case (state)
            ST_IDLE: begin
                if (do_refresh)                  state_nxt = ST_REF;
                else if (do_preacharge)          state_nxt = ST_PRE;
                else if (do_load_mod)            state_nxt = ST_MRS;
                else if (do_writea || do_reada)  state_nxt = ST_ACT;
            end
            ST_ACT: begin
                if (RCD_CYC != '0) begin
                    state_nxt = ST_RCD; t_load = 1'b1; t_val = RCD_CYC;
                end else begin
                    state_nxt = ST_RW;
                end
            end
            ST_RCD: if (t_done) state_nxt = ST_RW;
            ST_RW: begin
                // Reads stay in DATA through CAS latency plus the burst; writes
                // already drove their first beat in RW.
                if (!wr_q) begin
                    state_nxt = ST_DATA; t_load = 1'b1; t_val = RD_CYC;
                end else if (WR_CYC != '0) begin
                    state_nxt = ST_DATA; t_load = 1'b1; t_val = WR_CYC;
                end else begin
                    state_nxt = ST_WAIT; t_load = 1'b1; t_val = RP_CYC;
                end
            end
            ST_DATA: if (t_done) begin
                state_nxt = ST_WAIT; t_load = 1'b1; t_val = RP_CYC;
            end
            ST_PRE: begin
                if (PRE_CYC != '0) begin
                    state_nxt = ST_WAIT; t_load = 1'b1; t_val = PRE_CYC;
                end else state_nxt = ST_IDLE;
            end
            ST_REF: begin
                if (RFC_CYC != '0) begin
                    state_nxt = ST_WAIT; t_load = 1'b1; t_val = RFC_CYC;
                end else state_nxt = ST_IDLE;
            end
            ST_MRS: begin
                if (MRD_CYC != '0) begin
                    state_nxt = ST_WAIT; t_load = 1'b1; t_val = MRD_CYC;
                end else state_nxt = ST_IDLE;
            end
            ST_WAIT: if (t_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            col_q   <= '0;
            cmd_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Busy drops everything; in IDLE only the priority losers are errors
            cmd_err <= (state != ST_IDLE) ? (req != 5'd0) : req_multi;
            if (state == ST_IDLE && state_nxt == ST_ACT) begin
                wr_q   <= do_writea;
                bank_q <= addr[ADDR_W-1 -: BANKSIZE];
                col_q  <= addr[COLSIZE-1:0];
            end
        end
    end

    // Column address with A10 set selects auto-precharge; PRE uses A10 for all banks
    always_comb begin
        rw_addr                 = '0;
        rw_addr[COLSIZE-1:0]    = col_q;
        rw_addr[10]             = 1'b1;
        pre_addr                = '0;
        pre_addr[10]            = 1'b1;
    end

    // Pins are registered from the next state so a command appears in the
    // same cycle its state is current. ba/addr hold during NOP.
    always_ff @(posedge clk0 or posedge reset) begin
        if (reset) begin
            sdr_cs_n                         <= 1'b0;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
            sdr_ba                           <= '0;
            sdr_addr                         <= '0;
        end else begin
            sdr_cs_n                         <= 1'b0;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_ACT: begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_ACT;
                        sdr_ba   <= addr[ADDR_W-1 -: BANKSIZE];
                        sdr_addr <= addr[COLSIZE +: ROWSIZE];
                    end
                    ST_RW: begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= wr_q ? CMD_WRITE : CMD_READ;
                        sdr_ba   <= bank_q;
                        sdr_addr <= rw_addr;
                    end
                    ST_PRE: begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_PRE;
                        sdr_addr <= pre_addr;
                    end
                    ST_REF: {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_REF;
                    ST_MRS: begin
                        {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_MRS;
                        sdr_ba   <= '0;
                        sdr_addr <= mode_reg;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy     = (state != ST_IDLE);
    assign cmd_ack  = (state == ST_RW) || (state == ST_PRE) ||
                      (state == ST_REF) || (state == ST_MRS);
    assign oe       = wr_q && ((state == ST_RW) || (state == ST_DATA));
    // DATA for a read covers CAS latency then the burst; the burst is the tail
    assign rd_valid = !wr_q && (state == ST_DATA) && (t_count <= BL_CNT);

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
module tb_sdram_cmd_sequencer;

    localparam int ROWSIZE = 12, COLSIZE = 9, BANKSIZE = 2;
    localparam int T_RCD = 2, CAS_LAT = 2, BURST_LEN = 4;
    localparam int T_RP = 2, T_RFC = 7, T_MRD = 2;
    localparam int MAXC = 1024;

    logic        clk0 = 1'b0;
    logic        reset = 1'b1;
    logic        do_reada = 1'b0, do_writea = 1'b0, do_refresh = 1'b0;
    logic        do_preacharge = 1'b0, do_load_mod = 1'b0;
    logic [22:0] addr = '0;
    logic [11:0] mode_reg = '0;
    logic        sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [1:0]  sdr_ba;
    logic [11:0] sdr_addr;
    logic        oe, rd_valid, cmd_ack, busy, cmd_err;

    always #5 clk0 = ~clk0;

    sdram_cmd_sequencer #(
        .ROWSIZE(ROWSIZE), .COLSIZE(COLSIZE), .BANKSIZE(BANKSIZE),
        .T_RCD(T_RCD), .CAS_LAT(CAS_LAT), .BURST_LEN(BURST_LEN),
        .T_RP(T_RP), .T_RFC(T_RFC), .T_MRD(T_MRD)
    ) dut (
        .clk0(clk0), .reset(reset),
        .do_reada(do_reada), .do_writea(do_writea), .do_refresh(do_refresh),
        .do_preacharge(do_preacharge), .do_load_mod(do_load_mod),
        .addr(addr), .mode_reg(mode_reg),
        .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
        .sdr_ba(sdr_ba), .sdr_addr(sdr_addr),
        .oe(oe), .rd_valid(rd_valid), .cmd_ack(cmd_ack), .busy(busy), .cmd_err(cmd_err)
    );

    // Expected per-cycle outputs, filled by the model when a request is seen
    logic [2:0]  e_cmd  [MAXC];
    logic [1:0]  e_ba   [MAXC];
    logic [11:0] e_addr [MAXC];
    bit          e_ab [MAXC], e_a10 [MAXC], e_oe [MAXC], e_rv [MAXC];
    bit          e_ack [MAXC], e_busy [MAXC], e_err [MAXC];

    int cyc = 0, idle_from = 0;
    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr(input int from);
        for (int k = from; k < MAXC; k++) begin
            e_cmd[k] = 3'b111; e_ba[k] = '0; e_addr[k] = '0;
            e_ab[k] = 0; e_a10[k] = 0; e_oe[k] = 0; e_rv[k] = 0;
            e_ack[k] = 0; e_busy[k] = 0; e_err[k] = 0;
        end
    endtask

    // kind: 0 read, 1 write, 2 refresh, 3 precharge, 4 load mode
    task automatic sched(input int n, input int kind, input logic [22:0] a,
                         input logic [11:0] mr, output int idle);
        int rw, first;
        case (kind)
            0, 1: begin
                e_cmd[n+1] = 3'b011; e_ab[n+1] = 1; e_ba[n+1] = a[22:21]; e_addr[n+1] = a[20:9];
                rw = n + 1 + T_RCD;
                e_cmd[rw] = (kind == 1) ? 3'b100 : 3'b101;
                e_ab[rw] = 1; e_ba[rw] = a[22:21]; e_addr[rw] = {2'b01, 1'b0, a[8:0]};
                e_ack[rw] = 1;
                first = (kind == 1) ? rw : rw + CAS_LAT;
                for (int i = 0; i < BURST_LEN; i++)
                    if (kind == 1) e_oe[first+i] = 1; else e_rv[first+i] = 1;
                idle = first + BURST_LEN - 1 + T_RP + 1;
            end
            2: begin e_cmd[n+1] = 3'b001; e_ack[n+1] = 1; idle = n + 1 + T_RFC; end
            3: begin e_cmd[n+1] = 3'b010; e_ack[n+1] = 1; e_a10[n+1] = 1; idle = n + 1 + T_RP; end
            default: begin
                e_cmd[n+1] = 3'b000; e_ack[n+1] = 1; e_ab[n+1] = 1;
                e_ba[n+1] = '0; e_addr[n+1] = mr; idle = n + 1 + T_MRD;
            end
        endcase
        for (int k = n + 1; k < idle; k++) e_busy[k] = 1;
    endtask

    // Model: watches requests at each edge and schedules the expected timeline
    always @(posedge clk0) begin
        int c, nreq, kind;
        logic [4:0] r;
        c = cyc;
        r = {do_refresh, do_preacharge, do_load_mod, do_writea, do_reada};
        nreq = $countones(r);
        if (reset) begin
            clr(c + 1);
            idle_from = c + 1;
        end else if (nreq > 0) begin
            if (c >= idle_from) begin
                kind = do_refresh ? 2 : do_preacharge ? 3 : do_load_mod ? 4 : do_writea ? 1 : 0;
                sched(c, kind, addr, mode_reg, idle_from);
                e_err[c+1] = (nreq > 1);
            end else begin
                e_err[c+1] = 1;
            end
        end
        cyc = c + 1;
    end

    // Compare every cycle outside reset
    always @(negedge clk0) begin
        int c;
        c = cyc;
        if (!reset && c >= 1 && c < MAXC) begin
            chk("cmd", {sdr_ras_n, sdr_cas_n, sdr_we_n}, e_cmd[c]);
            chk("cs_n", sdr_cs_n, 1'b0);
            chk("oe", oe, e_oe[c]);
            chk("rd_valid", rd_valid, e_rv[c]);
            chk("cmd_ack", cmd_ack, e_ack[c]);
            chk("busy", busy, e_busy[c]);
            chk("cmd_err", cmd_err, e_err[c]);
            if (e_ab[c]) begin
                chk("ba", sdr_ba, e_ba[c]);
                chk("addr", sdr_addr, e_addr[c]);
            end
            if (e_a10[c]) chk("pre_a10", sdr_addr[10], 1'b1);
        end
    end

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] r);
        {do_refresh, do_preacharge, do_load_mod, do_writea, do_reada} = r;
    endtask

    localparam logic [22:0] A0 = {2'b01, 12'h155, 9'h0A3};

    initial begin
        int n;
        #25;
        chk("rst_cmd", {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, 4'b0111);
        chk("rst_ba_addr", {sdr_ba, sdr_addr}, 14'h0);
        chk("rst_strobes", {oe, rd_valid, cmd_ack, busy, cmd_err}, 5'b0);
        #6 reset = 1'b0;
        go(4);

        // Read with auto-precharge; addr changed after acceptance must not matter
        n = cyc; addr = A0; drive(5'b00001);
        go(n + 1); drive(5'b0); addr = 23'h7FFFFF;
        chk("rd_act", {sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr}, {3'b011, 2'd1, 12'h155});
        chk("rd_busy1", busy, 1'b1);
        go(n + 3);
        chk("rd_read", {sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr}, {3'b101, 2'd1, 12'h4A3});
        chk("rd_ack", cmd_ack, 1'b1);
        go(n + 4); chk("rd_rv4", rd_valid, 1'b0);
        go(n + 5); chk("rd_rv5", rd_valid, 1'b1);
        go(n + 8); chk("rd_rv8", rd_valid, 1'b1);
        go(n + 9); chk("rd_rv9", rd_valid, 1'b0);
        go(n + 10); chk("rd_busy10", busy, 1'b1);
        go(n + 11); chk("rd_busy11", busy, 1'b0);
        go(n + 12);

        // Write burst with a precharge request dropped mid-burst
        n = cyc; addr = A0; drive(5'b00010);
        go(n + 1); drive(5'b0);
        go(n + 3);
        chk("wr_write", {sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr}, {3'b100, 12'h4A3});
        chk("wr_ack_oe", {cmd_ack, oe, rd_valid}, 3'b110);
        go(n + 4); drive(5'b01000);
        go(n + 5); drive(5'b0);
        chk("wr_err", cmd_err, 1'b1);
        chk("wr_oe5", oe, 1'b1);
        go(n + 6); chk("wr_oe6", oe, 1'b1); chk("wr_err_once", cmd_err, 1'b0);
        go(n + 7); chk("wr_oe7", oe, 1'b0);
        go(n + 8); chk("wr_busy8", busy, 1'b1);
        go(n + 9); chk("wr_busy9", busy, 1'b0);
        go(n + 10);

        // Refresh beats read in the same cycle; next request gated by tRFC
        n = cyc; addr = A0; drive(5'b10001);
        go(n + 1); drive(5'b0);
        chk("ref_cmd", {sdr_ras_n, sdr_cas_n, sdr_we_n}, 3'b001);
        chk("ref_ack_err", {cmd_ack, cmd_err}, 2'b11);
        go(n + 2); chk("ref_err_once", cmd_err, 1'b0);
        go(n + 3); chk("ref_no_act", {sdr_ras_n, sdr_cas_n, sdr_we_n}, 3'b111);
        go(n + 7); chk("ref_busy7", busy, 1'b1); drive(5'b00001);
        go(n + 8); chk("ref_busy8", busy, 1'b0); chk("ref_late_err", cmd_err, 1'b1);
        go(n + 9); drive(5'b0);
        chk("ref_next_act", {sdr_ras_n, sdr_cas_n, sdr_we_n}, 3'b011);
        go(n + 20);

        // Load mode register
        n = cyc; mode_reg = 12'h023; drive(5'b00100);
        go(n + 1); drive(5'b0); mode_reg = 12'hFFF;
        chk("mrs_cmd", {sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_ba, sdr_addr}, {3'b000, 2'd0, 12'h023});
        go(n + 2); chk("mrs_busy2", busy, 1'b1);
        go(n + 3); chk("mrs_busy3", busy, 1'b0);
        go(n + 4);

        // Precharge all
        n = cyc; drive(5'b01000);
        go(n + 1); drive(5'b0);
        chk("pre_cmd", {sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr[10]}, 4'b0101);
        go(n + 3); chk("pre_busy3", busy, 1'b0);
        go(n + 4);

        // Reset during the ACT cycle of a read aborts it
        n = cyc; addr = A0; drive(5'b00001);
        go(n + 1); drive(5'b0);
        chk("rst_mid_act", {sdr_ras_n, sdr_cas_n, sdr_we_n}, 3'b011);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_nop", {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n}, 4'b0111);
        chk("rst_mid_busy", {busy, rd_valid}, 2'b00);
        go(n + 2); reset = 1'b0;
        go(n + 5); chk("rst_mid_rv", rd_valid, 1'b0);
        go(n + 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: test did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule
